zion_basic_circuit_lib_pipe_dff: RTL and testbench
==================================================

Name: zion_basic_circuit_lib_pipe_dff

Overview:
Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data, each stage with its own valid bit, under valid/ready flow control.
Successor to the plain reset DFF, adding:
- configurable depth
- per-stage valid tracking
- backpressure with bubble collapsing
- synchronous flush

Used to retime long datapaths between producer/consumer blocks without losing throughput under stall.

Parameters:
WIDTH_IN, 8, width of iDat; must equal WIDTH_OUT.
WIDTH_OUT, 8, width of oDat.
DEPTH, 2, number of register stages (0 = combinational pass-through, 1..64 legal).
INI_DATA, '0, data value of every stage after reset or clear.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active high; all state updates on posedge clk only.
clr  input  1  synchronous flush, active high.
iVld  input  1  input data valid.
iRdy  output  1  pipeline can accept input this cycle.
iDat  input  WIDTH_IN  input data.
oVld  output  1  output data valid (valid bit of last stage).
oRdy  input  1  consumer accepts output this cycle.
oDat  output  WIDTH_OUT  output data (last stage register).

Behaviour:
- State per stage k (0..DEPTH-1): vld[k], dat[k]. Stage 0 is the input side; stage DEPTH-1 drives oVld/oDat.
- Ready chain (combinational):
  - rdy[DEPTH] = oRdy.
  - rdy[k] = !vld[k] | rdy[k+1].
  - iRdy = rdy[0] & !clr.
  - A bubble anywhere in the chain lets all upstream stages advance, even while oRdy=0.
- Stage update when rdy[k]=1:
  - vld[k] <= vld[k-1], with iVld&iRdy used in place of vld[k-1] for stage 0.
  - dat[k] <= dat[k-1] (iDat for stage 0), loaded only when the upstream valid is 1.
  - dat[k] holds otherwise; there is no data toggling on bubbles.
- Stage hold when rdy[k]=0: vld[k] and dat[k] unchanged.
- Transfers: input transfer on iVld&iRdy; output transfer on oVld&oRdy.
- Ordering and integrity: order preserved; no loss or duplication.
- Latency: exactly DEPTH cycles from input transfer to oVld, when no stalls are present and the pipe starts empty.
- Throughput: 1 transfer/cycle sustained while oRdy=1.
- Capacity: DEPTH entries. When full and oRdy=0, iRdy=0. When full and oRdy=1, iRdy=1, so a simultaneous in/out transfer is allowed.
- Reset:
  - rst=1 at posedge: all vld <= 0 and all dat <= INI_DATA.
  - Resulting outputs: oVld=0, oDat=INI_DATA.
  - iRdy=1 after reset as long as clr=0.
  - Reset mid-stream discards all in-flight entries.
- Clear:
  - clr=1 at posedge: same effect as reset.
  - iRdy=0 during clr; any input presented is not accepted.
  - An output handshake in the clr cycle still counts as a transfer of the current oDat.
  - rst has priority over clr.
- DEPTH=0: oVld=iVld, oDat=iDat, iRdy=oRdy; clr and rst have no effect.
- Elaboration checks:
  - WIDTH_IN != WIDTH_OUT, or DEPTH > 64 -> $error.
  - With CHECK_ERR_EXIT defined, $finish follows the error.

Optional Feature:
Macro ZION_PIPE_DFF_OCC_EN.
- Defined:
  - Adds output oCnt, width $clog2(DEPTH+1), equal to the number of set vld bits.
  - Maintained as a registered counter: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Reset/clear value 0.
  - Simulation assertion: oCnt == popcount(vld) every cycle.
- Undefined: no oCnt port, no counter logic.

Test Plan:
1. DEPTH=3, INI_DATA=8'hA5: assert rst for 2 cycles -> oVld=0, oDat=8'hA5, iRdy=1. Stream 8'h01..8'h05 with oRdy=1 -> 8'h01 appears on oDat at cycle 3 after accept; one output per cycle, in order.
2. DEPTH=3, oRdy=0: push 8'h10, 8'h11, 8'h12 -> iRdy drops to 0 after the 3rd accept. Raise oRdy with iVld=1 on 8'h13 -> 8'h10 out and 8'h13 in on the same cycle.
3. DEPTH=4, bubble collapse: inject 8'h20, idle 2 cycles, inject 8'h21 while oRdy=0 -> both entries pack toward the output. Occupancy 2; iRdy stays 1.
4. Flush with a full pipe (DEPTH=2, contents 8'h30, 8'h31) and clr=1 with iVld=1 on 8'h32 -> next cycle oVld=0, oDat=INI_DATA; 8'h32 never emerges.
5. rst and clr both asserted mid-stream -> reset result. Random iVld/oRdy for 10k cycles -> scoreboard shows no loss, no duplication, order preserved.
6. With ZION_PIPE_DFF_OCC_EN: run scenario 2 -> oCnt goes 0,1,2,3, holds at 3 during the simultaneous in/out cycle, returns to 0 after clr.

Source files
------------

// File: rtl/zion_basic_circuit_lib_pipe_dff.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapsing and synchronous flush.
// Defining ZION_PIPE_DFF_OCC_EN adds the registered occupancy output oCnt.
module zion_basic_circuit_lib_pipe_dff #(
  parameter int                   WIDTH_IN  = 8,
  parameter int                   WIDTH_OUT = 8,
  parameter int                   DEPTH     = 2,
  parameter logic [WIDTH_OUT-1:0] INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 iVld,
  output logic                 iRdy,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oVld,
  input  logic                 oRdy,
  output logic [WIDTH_OUT-1:0] oDat
`ifdef ZION_PIPE_DFF_OCC_EN
  ,
  output logic [((DEPTH < 1) ? 1 : $clog2(DEPTH + 1))-1:0] oCnt
`endif
);

`ifdef ZION_PIPE_DFF_OCC_EN
  localparam int CNT_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
`endif

  if (WIDTH_IN != WIDTH_OUT || DEPTH > 64) begin : g_param_check
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_basic_circuit_lib_pipe_dff: WIDTH_IN must equal WIDTH_OUT and DEPTH must be <= 64");
`else
    $error("zion_basic_circuit_lib_pipe_dff: WIDTH_IN must equal WIDTH_OUT and DEPTH must be <= 64");
`endif
  end

  if (DEPTH == 0) begin : g_passthru
    logic unused_ok;

    assign oVld      = iVld;
    assign oDat      = iDat;
    assign iRdy      = oRdy;
    assign unused_ok = &{1'b0, clk, rst, clr};
`ifdef ZION_PIPE_DFF_OCC_EN
    assign oCnt = '0;
`endif
  end else begin : g_pipe
    logic [DEPTH-1:0]     vld_q;
    logic [WIDTH_OUT-1:0] dat_q  [DEPTH];
    logic [DEPTH-1:0]     rdy;
    logic [DEPTH-1:0]     up_vld;
    logic [WIDTH_OUT-1:0] up_dat [DEPTH];
    logic                 in_fire;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      // Flattened form of rdy[k] = !vld[k] | rdy[k+1]: any bubble downstream or a ready sink.
      assign rdy[k] = oRdy | ~(&vld_q[DEPTH-1:k]);
      if (k == 0) begin : g_head
        assign up_vld[k] = in_fire;
        assign up_dat[k] = iDat;
      end else begin : g_body
        assign up_vld[k] = vld_q[k-1];
        assign up_dat[k] = dat_q[k-1];
      end
    end

    assign iRdy    = rdy[0] & ~clr;
    assign in_fire = iVld & iRdy;
    assign oVld    = vld_q[DEPTH-1];
    assign oDat    = dat_q[DEPTH-1];

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) dat_q[k] <= INI_DATA;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (rdy[k]) begin
            vld_q[k] <= up_vld[k];
            // Data only moves with a valid token, so bubbles never toggle the data regs.
            if (up_vld[k]) dat_q[k] <= up_dat[k];
          end
        end
      end
    end

`ifdef ZION_PIPE_DFF_OCC_EN
    logic             out_fire;
    logic [CNT_W-1:0] cnt_q;

    assign out_fire = vld_q[DEPTH-1] & oRdy;
    assign oCnt     = cnt_q;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt_q <= '0;
      end else if (in_fire && !out_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (out_fire && !in_fire) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    a_occ_matches_valids: assert property (@(posedge clk) disable iff (rst)
      $countones(vld_q) == int'(cnt_q));
`endif
  end

endmodule

// File: tb/tb_zion_basic_circuit_lib_pipe_dff.sv
// Bench for zion_basic_circuit_lib_pipe_dff: DEPTH 3/4/2/0 instances on shared stimulus,
// checked every cycle against a position-list model plus hand-derived scenario expectations.
module tb_zion_basic_circuit_lib_pipe_dff;
  localparam int NM = 3;

  logic       clk = 1'b0;
  logic       rst, clr, in_vld, out_rdy;
  logic [7:0] in_dat;
  logic       irdy_w [4];
  logic       ovld_w [4];
  logic [7:0] odat_w [4];
`ifdef ZION_PIPE_DFF_OCC_EN
  logic [1:0] cnt3;
  logic [2:0] cnt4;
  logic [1:0] cnt2;
  logic [0:0] cnt0;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;
  int   dep [NM] = '{3, 4, 2};
  logic [7:0] ini [NM] = '{8'hA5, 8'h5A, 8'hC3};

  // Model: entries in arrival order, each with the stage index it occupies.
  logic [7:0] m_dat  [NM][8];
  int         m_pos  [NM][8];
  int         m_n    [NM];
  logic [7:0] m_last [NM];

  always #5 clk = ~clk;

  zion_basic_circuit_lib_pipe_dff #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(3), .INI_DATA(8'hA5)) u_d3 (
    .clk(clk), .rst(rst), .clr(clr), .iVld(in_vld), .iRdy(irdy_w[0]), .iDat(in_dat),
    .oVld(ovld_w[0]), .oRdy(out_rdy), .oDat(odat_w[0])
`ifdef ZION_PIPE_DFF_OCC_EN
    , .oCnt(cnt3)
`endif
  );

  zion_basic_circuit_lib_pipe_dff #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(4), .INI_DATA(8'h5A)) u_d4 (
    .clk(clk), .rst(rst), .clr(clr), .iVld(in_vld), .iRdy(irdy_w[1]), .iDat(in_dat),
    .oVld(ovld_w[1]), .oRdy(out_rdy), .oDat(odat_w[1])
`ifdef ZION_PIPE_DFF_OCC_EN
    , .oCnt(cnt4)
`endif
  );

  zion_basic_circuit_lib_pipe_dff #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(2), .INI_DATA(8'hC3)) u_d2 (
    .clk(clk), .rst(rst), .clr(clr), .iVld(in_vld), .iRdy(irdy_w[2]), .iDat(in_dat),
    .oVld(ovld_w[2]), .oRdy(out_rdy), .oDat(odat_w[2])
`ifdef ZION_PIPE_DFF_OCC_EN
    , .oCnt(cnt2)
`endif
  );

  zion_basic_circuit_lib_pipe_dff #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(0), .INI_DATA(8'h00)) u_d0 (
    .clk(clk), .rst(rst), .clr(clr), .iVld(in_vld), .iRdy(irdy_w[3]), .iDat(in_dat),
    .oVld(ovld_w[3]), .oRdy(out_rdy), .oDat(odat_w[3])
`ifdef ZION_PIPE_DFF_OCC_EN
    , .oCnt(cnt0)
`endif
  );

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, m, act, exp, $time);
    end
  endtask

  // Can accept whenever the pipe is not full or the sink is draining; never during a flush.
  function automatic bit exp_irdy(int m);
    return ((m_n[m] < dep[m]) || out_rdy) && !clr;
  endfunction

  function automatic bit exp_ovld(int m);
    return (m_n[m] > 0) && (m_pos[m][0] == dep[m] - 1);
  endfunction

`ifdef ZION_PIPE_DFF_OCC_EN
  function automatic int occ_of(int m);
    case (m)
      0:       return int'(cnt3);
      1:       return int'(cnt4);
      default: return int'(cnt2);
    endcase
  endfunction
`endif

  task automatic model_step();
    int  d;
    int  stuck;
    bit  fire_in;
    for (int m = 0; m < NM; m++) begin
      d       = dep[m];
      fire_in = in_vld && exp_irdy(m);
      stuck   = 0;
      if (rst || clr) begin
        m_n[m]    = 0;
        m_last[m] = ini[m];
      end else begin
        if (exp_ovld(m) && out_rdy) begin
          for (int i = 1; i < m_n[m]; i++) begin
            m_dat[m][i-1] = m_dat[m][i];
            m_pos[m][i-1] = m_pos[m][i];
          end
          m_n[m]--;
        end else if (!out_rdy) begin
          // Entries packed solid against the stalled output stay put; everything behind moves up.
          while (stuck < m_n[m] && m_pos[m][stuck] == d - 1 - stuck) stuck++;
        end
        for (int i = stuck; i < m_n[m]; i++) begin
          m_pos[m][i]++;
          if (m_pos[m][i] == d - 1) m_last[m] = m_dat[m][i];
        end
        if (fire_in) begin
          m_dat[m][m_n[m]] = in_dat;
          m_pos[m][m_n[m]] = 0;
          m_n[m]++;
          if (d == 1) m_last[m] = in_dat;
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < NM; m++) begin
      m_n[m]    = 0;
      m_last[m] = ini[m];
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int m = 0; m < NM; m++) begin
          chk("irdy", m, 32'(irdy_w[m]), 32'(exp_irdy(m)));
          chk("ovld", m, 32'(ovld_w[m]), 32'(exp_ovld(m)));
          chk("odat", m, 32'(odat_w[m]), 32'(m_last[m]));
`ifdef ZION_PIPE_DFF_OCC_EN
          chk("ocnt", m, occ_of(m), m_n[m]);
`endif
        end
        chk("d0_irdy", 3, 32'(irdy_w[3]), 32'(out_rdy));
        chk("d0_ovld", 3, 32'(ovld_w[3]), 32'(in_vld));
        chk("d0_odat", 3, 32'(odat_w[3]), 32'(in_dat));
`ifdef ZION_PIPE_DFF_OCC_EN
        chk("d0_ocnt", 3, 32'(cnt0), 32'(0));
`endif
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_dat = 8'h00; out_rdy = 1'b0;

    // Reset held for two edges.
    next_cycle();
    armed = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ovld", 0, 32'(ovld_w[0]), 32'(0));
    chk("rst_odat", 0, 32'(odat_w[0]), 32'h0000_00A5);
    chk("rst_irdy", 0, 32'(irdy_w[0]), 32'(1));
    next_cycle();

    // Stream 01..05 into a free-running sink; first word out three edges after accept.
    for (int c = 1; c <= 9; c++) begin
      out_rdy = 1'b1;
      in_vld  = (c <= 5);
      in_dat  = 8'(c);
      @(negedge clk);
      chk("s1_ovld", 0, 32'(ovld_w[0]), 32'(c >= 4 && c <= 8));
      if (c >= 4 && c <= 8) chk("s1_odat", 0, 32'(odat_w[0]), 32'(c - 3));
      next_cycle();
    end

    // Fill DEPTH=3 against a stalled sink, then a simultaneous in/out transfer.
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      in_dat = 8'h10 + 8'(i);
      @(negedge clk);
      chk("s2_irdy_fill", 0, 32'(irdy_w[0]), 32'(1));
`ifdef ZION_PIPE_DFF_OCC_EN
      chk("s2_ocnt_fill", 0, 32'(cnt3), 32'(i));
`endif
      next_cycle();
    end
    in_dat = 8'h13;
    @(negedge clk);
    chk("s2_irdy_full", 0, 32'(irdy_w[0]), 32'(0));
    chk("s2_ovld_full", 0, 32'(ovld_w[0]), 32'(1));
    chk("s2_odat_full", 0, 32'(odat_w[0]), 32'h10);
    next_cycle();
    out_rdy = 1'b1;
    @(negedge clk);
    chk("s2_irdy_swap", 0, 32'(irdy_w[0]), 32'(1));
    chk("s2_odat_swap", 0, 32'(odat_w[0]), 32'h10);
`ifdef ZION_PIPE_DFF_OCC_EN
    chk("s2_ocnt_swap", 0, 32'(cnt3), 32'(3));
`endif
    next_cycle();
    out_rdy = 1'b0;
    in_vld  = 1'b0;
    @(negedge clk);
    chk("s2_odat_after", 0, 32'(odat_w[0]), 32'h11);
    chk("s2_irdy_after", 0, 32'(irdy_w[0]), 32'(0));
`ifdef ZION_PIPE_DFF_OCC_EN
    chk("s2_ocnt_after", 0, 32'(cnt3), 32'(3));
`endif
    next_cycle();
    clr = 1'b1; out_rdy = 1'b1; in_vld = 1'b1; in_dat = 8'h3F;
    @(negedge clk);
    chk("s2_irdy_clr", 0, 32'(irdy_w[0]), 32'(0));
    chk("s2_odat_clr", 0, 32'(odat_w[0]), 32'h11);
    next_cycle();
    clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("s2_ovld_post", 0, 32'(ovld_w[0]), 32'(0));
    chk("s2_odat_post", 0, 32'(odat_w[0]), 32'h0000_00A5);
`ifdef ZION_PIPE_DFF_OCC_EN
    chk("s2_ocnt_post", 0, 32'(cnt3), 32'(0));
`endif
    next_cycle();

    // DEPTH=4 bubble collapse with the sink stalled throughout.
    for (int c = 1; c <= 7; c++) begin
      in_vld = (c == 1 || c == 4);
      in_dat = (c == 1) ? 8'h20 : 8'h21;
      @(negedge clk);
      if (c >= 5) begin
        chk("s3_ovld", 1, 32'(ovld_w[1]), 32'(1));
        chk("s3_odat", 1, 32'(odat_w[1]), 32'h20);
        chk("s3_irdy", 1, 32'(irdy_w[1]), 32'(1));
      end
      next_cycle();
    end
    in_vld = 1'b0; clr = 1'b1;
    next_cycle();
    clr = 1'b0;

    // DEPTH=2 flush of a full pipe while a new word is offered.
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1;
      in_dat = 8'h30 + 8'(i);
      next_cycle();
    end
    clr = 1'b1; in_dat = 8'h32;
    @(negedge clk);
    chk("s4_irdy_clr", 2, 32'(irdy_w[2]), 32'(0));
    chk("s4_odat_full", 2, 32'(odat_w[2]), 32'h30);
    next_cycle();
    clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("s4_ovld_post", 2, 32'(ovld_w[2]), 32'(0));
      chk("s4_odat_post", 2, 32'(odat_w[2]), 32'h0000_00C3);
      next_cycle();
    end

    // rst and clr together mid-stream.
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      in_dat = 8'h40 + 8'(i);
      next_cycle();
    end
    rst = 1'b1; clr = 1'b1; in_dat = 8'h43;
    @(negedge clk);
    chk("s5_irdy_rstclr", 0, 32'(irdy_w[0]), 32'(0));
    next_cycle();
    rst = 1'b0; clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("s5_ovld", 0, 32'(ovld_w[0]), 32'(0));
    chk("s5_odat", 0, 32'(odat_w[0]), 32'h0000_00A5);
    chk("s5_irdy", 0, 32'(irdy_w[0]), 32'(1));
    next_cycle();

    // Random traffic with alternating light and heavy backpressure, rare flushes and resets.
    for (int c = 0; c < 10000; c++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      in_dat  = 8'($urandom);
      out_rdy = ($urandom_range(0, 99) < (((c / 1000) % 2 == 1) ? 85 : 30));
      clr     = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      next_cycle();
    end
    rst = 1'b0; clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
